puf_challenge_ctrl: RTL and testbench
=====================================

Name: puf_challenge_ctrl

Overview:
- Synchronous controller that drives the arbiter-PUF delay line (`launch`, `challenge`) and consumes its `response`.
- Generates a sequence of challenges from an LFSR seeded by software.
- Fires each challenge REPS times and majority-votes the arbiter output.
- Packs RESP_BITS voted bits into one response word for the UART/readout logic downstream.

Parameters:
- N, 64: challenge width; must equal the delay line's N.
- RESP_BITS, 32: voted bits per response word (1..N).
- REPS, 7: evaluations per challenge; odd, 1..15.
- SETTLE_CYC, 4: cycles `launch` is held low before each evaluation; must be ≥1.
- EVAL_CYC, 8: cycles `launch` is held high; must be ≥3 to cover the 2-flop synchronizer.
- TAPS, 64'hD800000000000000: LFSR feedback mask, N bits.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- start  input  1  one-cycle request to begin a response word
- seed  input  N  LFSR seed, sampled when start is accepted
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse when resp_word is valid
- resp_word  output  RESP_BITS  voted response word
- launch  output  1  to delay_line launch
- challenge  output  N  to delay_line challenge
- puf_response  input  1  from delay_line response; asynchronous to clk
- unstable_cnt  output  16  present only with PUF_STATS_EN

Behaviour:
- Reset (async assert, sync release) clears all outputs and state to 0:
  - launch=0, challenge=0, busy=0, done=0, resp_word=0.
  - FSM to IDLE; the synchronizer flops also clear.
- puf_response passes through two flops (resp_s) before any use.
- All outputs are registered.
- FSM states:
  - IDLE: busy=0. start=1 accepted → LOAD. start is ignored in every other state.
  - LOAD (1 cycle): challenge<=seed, or N'h1 if seed==0. rep=0, ones=0, bitcnt=0, busy=1 → SETTLE.
  - SETTLE (SETTLE_CYC cycles): launch=0 → EVAL.
  - EVAL (EVAL_CYC cycles): launch=1. On the last cycle, ones<=ones+resp_s. Then:
    - rep<REPS-1: rep++ → SETTLE
    - otherwise → VOTE
  - VOTE (1 cycle): launch=0.
    - vote = (ones > REPS/2), with ones unsigned and 4 bits wide.
    - resp_word[bitcnt] <= vote.
    - LFSR step: challenge <= {challenge[N-2:0], ^(challenge & TAPS)}.
    - rep=0, ones=0.
    - bitcnt==RESP_BITS-1 → DONE; otherwise bitcnt++ → SETTLE.
  - DONE (1 cycle): done=1, busy=0 on the following edge → IDLE.
- challenge changes only in LOAD or VOTE, i.e. only while launch=0; it is never changed while launch=1.
- Bit k of resp_word is the vote for the k-th challenge after the seed (k=0 is the seed).
- resp_word bits not yet written keep their old values during a run.
- resp_word holds its value until the next LOAD.
  - LOAD does not clear it; all RESP_BITS bits are overwritten by run end.
- Latency: done is high in the cycle beginning 1 + RESP_BITS·(REPS·(SETTLE_CYC+EVAL_CYC)+1) rising edges after the edge that samples start.
  - Defaults: 2721.
- start asserted in the same cycle as done is ignored, since the FSM is in DONE and not IDLE.
- rst mid-run:
  - launch drops immediately (async) and the FSM returns to IDLE.
  - The partial word is discarded (resp_word=0).
  - No done pulse is produced.
- LFSR state of all zeros never occurs: the seed is guarded at LOAD, and TAPS must include bit N-1.

Optional Feature:
- Macro: PUF_STATS_EN.
- Defined:
  - unstable_cnt port exists.
  - Cleared at LOAD.
  - In VOTE, increments by 1 when ones≠0 and ones≠REPS.
  - Saturates at 16'hFFFF.
  - Holds after done.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Stub PUF, response = ^challenge[31:0], all defaults, seed=64'h1:
  - challenges are 1<<k (zero feedback bits);
  - resp_word=32'hFFFFFFFF;
  - done exactly 2721 edges after start;
  - checker confirms challenge is stable whenever launch=1.
- Stub response tied 0, seed=64'hDEADBEEF_CAFEF00D → resp_word=32'h0, busy high for the full run, single done pulse.
- seed=0 → first challenge driven is 64'h1; response stub = challenge[0] → resp_word[0]=1.
- Stub flips response on evaluations 0,1,2 of each challenge (3 of 7 ones) → every vote 0; with PUF_STATS_EN, unstable_cnt=32.
  - Same stub with 4 of 7 ones → every vote 1, resp_word=32'hFFFFFFFF.
- rst pulsed at cycle 500 of a run → launch=0, busy=0, resp_word=0 asynchronously; no done.
  - A subsequent start completes normally with correct resp_word.
- start pulsed while busy, and again in the done cycle → both ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/puf_challenge_ctrl.sv
// Arbiter-PUF challenge sequencer: LFSR challenges, REPS-fold majority vote, RESP_BITS-bit word.
// Latency 1+RESP_BITS*(REPS*(SETTLE_CYC+EVAL_CYC)+1) cycles start->done; start ignored while busy. Option: PUF_STATS_EN.
module puf_challenge_ctrl #(
  parameter int N = 64,
  parameter int RESP_BITS = 32,
  parameter int REPS = 7,
  parameter int SETTLE_CYC = 4,
  parameter int EVAL_CYC = 8,
  parameter logic [N-1:0] TAPS = 64'hD800000000000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N-1:0]         seed,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] resp_word,
  output logic                 launch,
  output logic [N-1:0]         challenge,
  input  logic                 puf_response
`ifdef PUF_STATS_EN
  ,
  output logic [15:0]          unstable_cnt
`endif
);

  localparam int TMAX = (SETTLE_CYC > EVAL_CYC) ? SETTLE_CYC : EVAL_CYC;
  localparam int CW   = $clog2(TMAX + 1);
  localparam int BW   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] EVAL_LAST   = CW'(EVAL_CYC - 1);
  localparam logic [3:0]    REP_LAST    = 4'(REPS - 1);
  localparam logic [3:0]    REPS_ALL    = 4'(REPS);
  localparam logic [3:0]    REPS_HALF   = 4'(REPS / 2);
  localparam logic [BW-1:0] BIT_LAST    = BW'(RESP_BITS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, EVAL, VOTE, DONE} state_t;

  state_t          state, nstate;
  logic [CW-1:0]   tmr;
  logic [3:0]      rep;
  logic [3:0]      ones;
  logic [BW-1:0]   bitcnt;
  logic            resp_meta, resp_s;
  logic            settle_last, eval_last, vote;
  logic            launch_nxt, busy_nxt, done_nxt;

  assign settle_last = (tmr == SETTLE_LAST);
  assign eval_last   = (tmr == EVAL_LAST);
  assign vote        = (ones > REPS_HALF);

  // puf_response is asynchronous to clk; only resp_s is ever used
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_meta <= 1'b0;
      resp_s    <= 1'b0;
    end else begin
      resp_meta <= puf_response;
      resp_s    <= resp_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = LOAD;
      LOAD:    nstate = SETTLE;
      SETTLE:  if (settle_last) nstate = EVAL;
      EVAL:    if (eval_last) nstate = (rep == REP_LAST) ? VOTE : SETTLE;
      VOTE:    nstate = (bitcnt == BIT_LAST) ? DONE : SETTLE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops
  always_comb begin
    launch_nxt = (nstate == EVAL);
    busy_nxt   = (nstate != IDLE);
    done_nxt   = (nstate == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      launch <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      launch <= launch_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
    end else if (nstate != state) begin
      tmr <= '0;
    end else if (state == SETTLE || state == EVAL) begin
      tmr <= tmr + CW'(1);
    end
  end

  // Challenge moves only on entry to LOAD or out of VOTE, both with launch low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      challenge <= '0;
      resp_word <= '0;
      rep       <= '0;
      ones      <= '0;
      bitcnt    <= '0;
    end else if (nstate == LOAD) begin
      challenge <= (seed == '0) ? N'(1) : seed;
      rep       <= '0;
      ones      <= '0;
      bitcnt    <= '0;
    end else if (state == EVAL && eval_last) begin
      ones <= ones + {3'b000, resp_s};
      if (rep != REP_LAST) rep <= rep + 4'd1;
    end else if (state == VOTE) begin
      resp_word[bitcnt] <= vote;
      challenge         <= {challenge[N-2:0], ^(challenge & TAPS)};
      rep               <= '0;
      ones              <= '0;
      if (bitcnt != BIT_LAST) bitcnt <= bitcnt + BW'(1);
    end
  end

`ifdef PUF_STATS_EN
  // Counts challenges whose REPS evaluations did not all agree
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unstable_cnt <= '0;
    end else if (nstate == LOAD) begin
      unstable_cnt <= '0;
    end else if (state == VOTE && ones != 4'd0 && ones != REPS_ALL &&
                 unstable_cnt != 16'hFFFF) begin
      unstable_cnt <= unstable_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// Directed bench for puf_challenge_ctrl with a behavioural delay-line stub selected by mode.
// Checks latency, votes, busy/done framing, async reset and challenge stability under launch.
module tb_puf_challenge_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] seed;
  logic        busy;
  logic        done;
  logic [31:0] resp_word;
  logic        launch;
  logic [63:0] challenge;
  logic        puf_response;
`ifdef PUF_STATS_EN
  logic [15:0] unstable_cnt;
`endif

  int          n_chk = 0;
  int          n_pass = 0;
  int          mode = 0;
  int          launch_cnt = 0;
  int          ev_base = 0;
  int          cur;
  int          seq_bad = 0;
  int          stab_bad = 0;
  int          done_cnt = 0;
  bit          seq_on = 1'b0;
  logic        prev_launch = 1'b0;
  logic [63:0] prev_chal = '0;
  logic [63:0] first_chal = '0;
  logic [63:0] one64 = 64'h1;

  always #5 clk = ~clk;

  puf_challenge_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .seed         (seed),
    .busy         (busy),
    .done         (done),
    .resp_word    (resp_word),
    .launch       (launch),
    .challenge    (challenge),
    .puf_response (puf_response)
`ifdef PUF_STATS_EN
    ,
    .unstable_cnt (unstable_cnt)
`endif
  );

  // Delay-line stub; cur is the evaluation index within the current run
  always_comb begin
    cur = launch_cnt - ev_base - 1;
    if (cur < 0) cur = 0;
    puf_response = 1'b0;
    case (mode)
      0:       puf_response = ^challenge[31:0];
      2:       puf_response = challenge[0];
      3:       puf_response = ((cur % 7) < 3);
      4:       puf_response = ((cur % 7) < 4);
      default: puf_response = 1'b0;
    endcase
  end

  always @(posedge launch) begin
    if (launch_cnt == ev_base) first_chal <= challenge;
    if (seq_on && challenge != (one64 << ((launch_cnt - ev_base) / 7)))
      seq_bad <= seq_bad + 1;
    launch_cnt <= launch_cnt + 1;
  end

  always @(posedge clk) begin
    if (launch && prev_launch && challenge != prev_chal) stab_bad <= stab_bad + 1;
    prev_launch <= launch;
    prev_chal   <= challenge;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One full word; poke also pulses start mid-run and in the done cycle
  task automatic run_word(input logic [63:0] s, input int m, input bit poke);
    int cyc;
    int blo;
    int d0;
    mode    = m;
    ev_base = launch_cnt;
    seed    = s;
    d0      = done_cnt;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    blo = busy ? 0 : 1;
    while (!done && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!busy) blo++;
      if (poke && cyc == 100) start = 1'b1;
      if (poke && cyc == 101) start = 1'b0;
    end
    chk("latency", 64'(cyc), 64'd2721);
    chk("busy_run", 64'(blo), 64'd0);
    if (poke) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("done_width", 64'(done), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_idle", 64'(busy), 64'd0);
    chk("done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    seed  = '0;
    #2;
    chk("rst_launch", 64'(launch), 64'd0);
    chk("rst_challenge", challenge, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_resp", 64'(resp_word), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    seq_on = 1'b1;
    run_word(64'h1, 0, 1'b0);
    seq_on = 1'b0;
    chk("seq_shift", 64'(seq_bad), 64'd0);
    chk("resp_parity", 64'(resp_word), 64'hFFFFFFFF);

    run_word(64'hDEADBEEF_CAFEF00D, 1, 1'b1);
    chk("resp_zero", 64'(resp_word), 64'd0);

    mode    = 0;
    ev_base = launch_cnt;
    seed    = 64'h1;
    d0      = done_cnt;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (505) @(posedge clk);
    #1;
    chk("pre_rst_resp", 64'(resp_word), 64'h1F);
    chk("pre_rst_launch", 64'(launch), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_launch", 64'(launch), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_resp", 64'(resp_word), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
    run_word(64'h1, 0, 1'b0);
    chk("resp_after_rst", 64'(resp_word), 64'hFFFFFFFF);

    run_word(64'h0, 2, 1'b0);
    chk("seed0_first", first_chal, 64'h1);
    chk("seed0_resp", 64'(resp_word), 64'h1);

    run_word(64'h1, 3, 1'b0);
    chk("vote_3of7", 64'(resp_word), 64'd0);
`ifdef PUF_STATS_EN
    chk("unstable_3of7", 64'(unstable_cnt), 64'd32);
`endif

    run_word(64'h1, 4, 1'b0);
    chk("vote_4of7", 64'(resp_word), 64'hFFFFFFFF);
`ifdef PUF_STATS_EN
    chk("unstable_4of7", 64'(unstable_cnt), 64'd32);
`endif

    chk("launch_stable", 64'(stab_bad), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
